// File: rtl/aes_uart_tx.sv
// ---------------------------------------------------------------------------
// aes_uart_tx
//
// Transmit end of the RS-232 AES link. On an accepted start the 128-bit
// ciphertext and the decrypt self-check flag are latched, then sent as 16
// bytes of 8N1 UART (most significant byte first, each byte LSB first).
// An optional 17th status byte (8'h01 = check passed, 8'h00 = failed)
// follows the ciphertext.
//
// Parameters:
//   CLKS_PER_BIT  - clk cycles per UART bit (>= 2)
//   APPEND_STATUS - 1 = append the status byte, 0 = ciphertext only
//
// Ports:
//   clk      - system clock, all logic on the rising edge
//   rst      - synchronous active-high reset, aborts any transfer
//   start    - send request, honoured only while busy is low
//   data_in  - 128-bit ciphertext, latched on the accepting edge
//   check_ok - self-check flag, latched on the accepting edge
//   tx       - UART line, idles high
//   busy     - high while the frame sequence is on the line
//   done     - one-cycle pulse after the final stop bit
//   byte_idx - index of the byte on the line (0..16), 0 when idle
// ---------------------------------------------------------------------------
module aes_uart_tx #(
    parameter int CLKS_PER_BIT  = 434,
    parameter bit APPEND_STATUS = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] data_in,
    input  logic         check_ok,
    output logic         tx,
    output logic         busy,
    output logic         done,
    output logic [4:0]   byte_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START_BIT,
        S_DATA,
        S_STOP_BIT,
        S_DONE
    } state_t;

    localparam int            TW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TICK_MAX  = TW'(CLKS_PER_BIT - 1);
    localparam logic [4:0]    LAST_BYTE = APPEND_STATUS ? 5'd16 : 5'd15;

    state_t         state, state_n;
    logic [TW-1:0]  timer, timer_n;
    logic [2:0]     bit_cnt, bit_cnt_n;
    logic [4:0]     byte_cnt, byte_cnt_n;
    logic [127:0]   shift_reg, shift_n;
    logic           status_q, status_n;

    logic           tx_n;
    logic           busy_n;
    logic           done_n;
    logic [4:0]     byte_idx_n;
    logic [7:0]     cur_byte_n;
    logic           tick;

    assign tick = (timer == TICK_MAX);

    // State register. The outputs are registered from the next-state values
    // so that they change on the same edge as the state itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            timer     <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            shift_reg <= '0;
            status_q  <= 1'b0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            byte_idx  <= '0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            bit_cnt   <= bit_cnt_n;
            byte_cnt  <= byte_cnt_n;
            shift_reg <= shift_n;
            status_q  <= status_n;
            tx        <= tx_n;
            busy      <= busy_n;
            done      <= done_n;
            byte_idx  <= byte_idx_n;
        end
    end

    // Next-state and counter logic. The DONE cycle has busy low, so a start
    // seen there is accepted exactly like one seen in IDLE.
    always_comb begin
        state_n    = state;
        timer_n    = timer;
        bit_cnt_n  = bit_cnt;
        byte_cnt_n = byte_cnt;
        shift_n    = shift_reg;
        status_n   = status_q;

        case (state)
            S_IDLE, S_DONE: begin
                if (state == S_DONE) begin
                    state_n = S_IDLE;
                end
                if (start) begin
                    state_n    = S_START_BIT;
                    timer_n    = '0;
                    bit_cnt_n  = '0;
                    byte_cnt_n = '0;
                    shift_n    = data_in;
                    status_n   = check_ok;
                end
            end

            S_START_BIT: begin
                timer_n = tick ? '0 : timer + 1'b1;
                if (tick) begin
                    state_n   = S_DATA;
                    bit_cnt_n = '0;
                end
            end

            S_DATA: begin
                timer_n = tick ? '0 : timer + 1'b1;
                if (tick) begin
                    if (bit_cnt == 3'd7) begin
                        state_n = S_STOP_BIT;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end

            S_STOP_BIT: begin
                timer_n = tick ? '0 : timer + 1'b1;
                if (tick) begin
                    if (byte_cnt == LAST_BYTE) begin
                        state_n = S_DONE;
                    end else begin
                        // Next ciphertext byte moves into the top of the shifter.
                        state_n    = S_START_BIT;
                        byte_cnt_n = byte_cnt + 1'b1;
                        shift_n    = {shift_reg[119:0], 8'h00};
                    end
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Output logic, evaluated on the next-state values. Byte 16 is the status
    // byte; bytes 0..15 always sit in the top eight bits of the shifter.
    always_comb begin
        cur_byte_n = (byte_cnt_n == 5'd16) ? {7'b0, status_n} : shift_n[127:120];
        tx_n       = 1'b1;
        busy_n     = 1'b0;
        done_n     = 1'b0;
        byte_idx_n = '0;

        case (state_n)
            S_START_BIT: begin
                tx_n       = 1'b0;
                busy_n     = 1'b1;
                byte_idx_n = byte_cnt_n;
            end
            S_DATA: begin
                tx_n       = cur_byte_n[bit_cnt_n];
                busy_n     = 1'b1;
                byte_idx_n = byte_cnt_n;
            end
            S_STOP_BIT: begin
                tx_n       = 1'b1;
                busy_n     = 1'b1;
                byte_idx_n = byte_cnt_n;
            end
            S_DONE: begin
                done_n = 1'b1;
            end
            default: begin
                tx_n = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_aes_uart_tx
//
// Bench for aes_uart_tx with CLKS_PER_BIT=4. Two instances are driven: dut0
// without the status byte and dut1 with it. Each accepted start pushes the
// expected bytes and done cycle into per-instance queues; a monitor running
// on the falling clock edge decodes the UART line and checks busy, done,
// byte_idx and idle levels against the bench's own timing model.
// ---------------------------------------------------------------------------
module tb_aes_uart_tx;

    localparam int CPB = 4;

    typedef struct packed {
        logic [7:0] val;
        logic [4:0] idx;
    } exp_byte_t;

    localparam logic [127:0] V1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] V2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] V3 = 128'hffa5015a3cc3807e0f10f0e1d2b4963c;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start0 = 1'b0;
    logic         start1 = 1'b0;
    logic [127:0] data_in = '0;
    logic         check_ok = 1'b0;
    logic         tx0, busy0, done0;
    logic         tx1, busy1, done1;
    logic [4:0]   idx0, idx1;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    exp_byte_t bq0[$];
    exp_byte_t bq1[$];
    int        dq0[$];
    int        dq1[$];
    int        busy_from [2];
    int        busy_to   [2];

    bit         dec_act [2];
    int         dec_cnt [2];
    logic [7:0] dec_sh  [2];
    logic [4:0] dec_idx [2];
    logic       prev_tx [2];

    always #5 clk = ~clk;

    // Cycle K is the period that follows the K-th rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    aes_uart_tx #(.CLKS_PER_BIT(CPB), .APPEND_STATUS(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .data_in(data_in),
        .check_ok(check_ok), .tx(tx0), .busy(busy0), .done(done0),
        .byte_idx(idx0)
    );

    aes_uart_tx #(.CLKS_PER_BIT(CPB), .APPEND_STATUS(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .data_in(data_in),
        .check_ok(check_ok), .tx(tx1), .busy(busy1), .done(done1),
        .byte_idx(idx1)
    );

    task automatic checkOutput(input string name, input int d,
                               input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s dut%0d cycle %0d: got %0h, expected %0h",
                     name, d, cyc, actual, expected);
        end
    endtask

    task automatic clearModel();
        for (int d = 0; d < 2; d++) begin
            busy_from[d] = 1;
            busy_to[d]   = 0;
            dec_act[d]   = 1'b0;
            dec_cnt[d]   = 0;
            prev_tx[d]   = 1'b1;
        end
        bq0.delete();
        bq1.delete();
        dq0.delete();
        dq1.delete();
    endtask

    task automatic pushFrame(input int d, input logic [127:0] data,
                             input logic ok, input int c);
        exp_byte_t e;
        for (int i = 0; i < 16; i++) begin
            e.val = data[127 - 8*i -: 8];
            e.idx = 5'(i);
            if (d == 0) bq0.push_back(e); else bq1.push_back(e);
        end
        if (d == 1) begin
            e.val = {7'b0, ok};
            e.idx = 5'd16;
            bq1.push_back(e);
            dq1.push_back(c + 170*CPB);
        end else begin
            dq0.push_back(c + 160*CPB);
        end
    endtask

    // Called at posedge+2; returns the first busy cycle or -1 if ignored.
    task automatic applyStimulus(input int d, input logic [127:0] data,
                                 input logic ok, output int c);
        int  x;
        bit  accepted;
        data_in  = data;
        check_ok = ok;
        if (d == 0) start0 = 1'b1; else start1 = 1'b1;
        x        = cyc;
        accepted = !(x >= busy_from[d] && x <= busy_to[d]);
        c        = -1;
        if (accepted) begin
            c            = x + 1;
            busy_from[d] = c;
            busy_to[d]   = c + ((d == 1) ? 170*CPB : 160*CPB) - 1;
            pushFrame(d, data, ok, c);
        end
        @(posedge clk); #2;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic doReset(input int n);
        rst = 1'b1;
        @(posedge clk); #2;
        clearModel();
        repeat (n - 1) begin
            @(posedge clk); #2;
        end
        rst = 1'b0;
    endtask

    task automatic monitorDut(input int d);
        logic       t, b, dn;
        logic [4:0] ix;
        bit         exp_busy;
        exp_byte_t  e;
        int         front;
        t  = (d == 0) ? tx0   : tx1;
        b  = (d == 0) ? busy0 : busy1;
        dn = (d == 0) ? done0 : done1;
        ix = (d == 0) ? idx0  : idx1;

        exp_busy = (cyc >= busy_from[d] && cyc <= busy_to[d]);
        checkOutput("busy", d, 32'(b), 32'(exp_busy));
        if (!exp_busy) begin
            checkOutput("idle_tx", d, 32'(t), 32'd1);
            checkOutput("idle_byte_idx", d, 32'(ix), 32'd0);
        end

        // A done pulse that never showed up by its cycle is reported missing.
        while (((d == 0) ? dq0.size() : dq1.size()) > 0) begin
            front = (d == 0) ? dq0[0] : dq1[0];
            if (front >= cyc) break;
            checkOutput("done_missing", d, 32'(front), 32'(cyc));
            if (d == 0) void'(dq0.pop_front()); else void'(dq1.pop_front());
        end
        if (dn === 1'b1) begin
            if (((d == 0) ? dq0.size() : dq1.size()) > 0) begin
                front = (d == 0) ? dq0.pop_front() : dq1.pop_front();
                checkOutput("done_cycle", d, 32'(cyc), 32'(front));
            end else begin
                checkOutput("unexpected_done", d, 32'd1, 32'd0);
            end
        end

        // UART decoder: sample each bit in the middle of its CPB cycles.
        if (rst) begin
            dec_act[d] = 1'b0;
        end else if (!dec_act[d] && prev_tx[d] === 1'b1 && t === 1'b0) begin
            dec_act[d] = 1'b1;
            dec_cnt[d] = 0;
        end
        if (dec_act[d]) begin
            if (dec_cnt[d] == 2) begin
                checkOutput("start_bit", d, 32'(t), 32'd0);
                dec_idx[d] = ix;
            end else if (dec_cnt[d] >= 6 && dec_cnt[d] <= 34 && (dec_cnt[d] % 4) == 2) begin
                dec_sh[d][(dec_cnt[d] - 6) / 4] = t;
            end else if (dec_cnt[d] == 38) begin
                checkOutput("stop_bit", d, 32'(t), 32'd1);
                if (((d == 0) ? bq0.size() : bq1.size()) > 0) begin
                    e = (d == 0) ? bq0.pop_front() : bq1.pop_front();
                    checkOutput("byte_value", d, 32'(dec_sh[d]), 32'(e.val));
                    checkOutput("byte_idx", d, 32'(dec_idx[d]), 32'(e.idx));
                end else begin
                    checkOutput("unexpected_byte", d, 32'(dec_sh[d]), 32'hffff_ffff);
                end
                dec_act[d] = 1'b0;
            end
            dec_cnt[d]++;
        end
        prev_tx[d] = t;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) monitorDut(d);
        end
    end

    initial begin
        int c;
        int c2;
        clearModel();
        @(posedge clk); #2;

        // Reset held three cycles, then 50 idle cycles checked by the monitor.
        $display("[TB] reset and idle");
        doReset(3);
        mon_en = 1'b1;
        waitCycles(50);

        $display("[TB] single frame, no status byte");
        applyStimulus(0, V1, 1'b0, c);
        checkOutput("accept_single", 0, 32'(c > 0), 32'd1);
        waitUntil(c + 645);

        $display("[TB] status byte, check_ok=1 then 0");
        applyStimulus(1, V1, 1'b1, c);
        waitUntil(c + 685);
        applyStimulus(1, V2, 1'b0, c);
        waitUntil(c + 685);

        $display("[TB] start while busy with changed data");
        applyStimulus(0, V2, 1'b1, c);
        waitUntil(c + 5*10*CPB + 8);
        applyStimulus(0, V3, 1'b0, c2);
        checkOutput("ignored_start", 0, 32'(c2), 32'hffff_ffff);
        waitUntil(c + 645);

        $display("[TB] back-to-back frames");
        applyStimulus(0, V3, 1'b0, c);
        waitUntil(c + 160*CPB);
        applyStimulus(0, V1, 1'b1, c2);
        checkOutput("b2b_start_cycle", 0, 32'(c2), 32'(c + 160*CPB + 1));
        waitUntil(c2 + 645);

        $display("[TB] reset mid-frame, then a fresh frame");
        applyStimulus(0, V2, 1'b0, c);
        waitUntil(c + 3*10*CPB + 5*CPB + 1);
        doReset(1);
        waitCycles(20);
        applyStimulus(0, V3, 1'b1, c);
        waitUntil(c + 645);

        checkOutput("bytes_pending", 0, 32'(bq0.size()), 32'd0);
        checkOutput("bytes_pending", 1, 32'(bq1.size()), 32'd0);
        checkOutput("dones_pending", 0, 32'(dq0.size()), 32'd0);
        checkOutput("dones_pending", 1, 32'(dq1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
